conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming 3x3 sliding-window generator that sits upstream of the PE array and adder tree. It accepts one IFM pixel per handshake in raster order, keeps two previous rows in line buffers, and emits the 3x3 window as nine parallel pixels. Output index ordering matches the adder tree's product inputs 0..8. Operation is stride 1 with no padding (valid convolution), one frame per `start`.

## Interface
- `DATA_WIDTH`, 8, pixel width (signed)
- `IMG_W`, 28, frame width in pixels (>= 3)
- `IMG_H`, 28, frame height in pixels (>= 3)
- `clk`  in  1  clock
- `rst_n`  in  1  reset: asynchronous, active-low
- `start`  in  1  one-cycle frame start; ignored while `busy`
- `pix_valid`  in  1  input pixel valid
- `pix_ready`  out  1  input pixel accepted when `pix_valid && pix_ready`
- `pix_data`  in  DATA_WIDTH  input pixel, raster order
- `win_valid`  out  1  window valid
- `win_ready`  in  1  downstream accepts window (drives the adder's `ready_adder`)
- `win_data`  out  9 x DATA_WIDTH  unpacked array; index 3*i+j = row i (0 = oldest), column j (0 = leftmost)
- `win_last`  out  1  qualifies the final window of the frame
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after the final window handshake

## Operation
- FSM states:
  - IDLE: on `start`, go to RUN and clear counters.
  - RUN: accept pixels. When the final window handshake (`win_valid && win_ready && win_last`) occurs, go to DONE.
  - DONE: lasts one cycle and asserts `done`, then returns to IDLE.
- `busy` = state != IDLE.
- `pix_ready` = (state == RUN) && pixel count < IMG_W*IMG_H && (!win_valid || win_ready). It is combinational and has no skid buffer.
- On each accepted pixel at (r,c):
  - Shift line buffer A (row r-1) and line buffer B (row r-2) by one entry.
  - Shift the window columns left.
  - Load the new rightmost column {B_out, A_out, pix_data} into rows 0, 1, 2.
  - Write `pix_data` into A, and A_out into B.
  - Advance column and row counters; the column wraps at IMG_W-1 and the row increments.
- A window is produced iff r >= 2 && c >= 2 for the accepted pixel. Windows straddling a row boundary (c < 2) are never emitted.
- Window count per frame: (IMG_H-2)*(IMG_W-2). `win_last` is set with the window from pixel (IMG_H-1, IMG_W-1).
- Line buffer contents are not reset. Validity comes only from the counters.
- `start` is ignored in RUN and DONE.
- Reset mid-frame: return to IDLE and drop the frame. No partial window is emitted.

## Timing
- Reset values: `pix_ready`=0, `win_valid`=0, `win_data` all 0, `win_last`=0, `busy`=0, `done`=0.
- Latency: `win_valid` rises the cycle after the handshake of the completing pixel.
- `win_data` and `win_last` stay stable while `win_valid && !win_ready`.
- `win_valid` falls the cycle after handshake, unless a new window is loaded in the same cycle.
- Handshake in and handshake out can coincide in one cycle, giving a sustained throughput of 1 pixel/cycle.
- IDLE to first `pix_ready`: 1 cycle after `start`.

## Configuration
- `CONV_WIN_STRIDE2_EN` defined:
  - A window is emitted only when r >= 2, c >= 2, (r-2) is even and (c-2) is even.
  - Count is ((IMG_H-3)/2+1)*((IMG_W-3)/2+1), using integer division.
  - `win_last` is on the last emitted window. If the final pixel does not emit, completion is the final pixel handshake, and `done` follows it by one cycle in the DONE state.
- Not defined: stride 1 as above.

## Structure
- Package `conv_pkg`:
  - `KERNEL`=3 and `WIN_SIZE`=9.
  - The FSM state enum `win_state_t` (IDLE, RUN, DONE).
  - The shared default `DATA_WIDTH`.
- Sub-module `line_buffer`: a DEPTH-entry shift register (DEPTH=IMG_W, WIDTH=DATA_WIDTH) with a shift enable and a tail output. It is instantiated twice (A, B).

## Test plan
- Reset mid-frame, IMG_W=IMG_H=5: reset after 12 pixels, then `start` and pixels 0..24 -> all outputs return to reset values; nine windows are emitted, first window = {0,1,2,5,6,7,10,11,12}.
- Full frame, IMG_W=IMG_H=5, `win_ready`=1, pixels 0..24 back-to-back:
  - Exactly 9 windows, in row-major window order.
  - Last window = {12,13,14,17,18,19,22,23,24} with `win_last`=1.
  - `done` pulses one cycle after the last window handshake.
- Backpressure: hold `win_ready`=0 for 4 cycles on the first window -> `pix_ready`=0 and `win_data` stable throughout; no pixel lost; next window = {1,2,3,6,7,8,11,12,13}.
- Row-wrap, IMG_W=5: pixels with c=0,1 on rows 3,4 -> no window emitted; the window after the wrap is {5,6,7,10,11,12,15,16,17}.
- `start` asserted during RUN -> ignored; counters unchanged; the frame completes normally with 9 windows.
- `CONV_WIN_STRIDE2_EN`, 5x5 frame -> 4 windows with top-left pixels 0, 2, 10, 12; `win_last` on the window with top-left 12.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the 3x3 sliding-window generator.
package conv_pkg;
    localparam int KERNEL     = 3;
    localparam int WIN_SIZE   = KERNEL * KERNEL;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } win_state_t;
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// Row-delay line: DEPTH-entry shift register, tail is the entry written DEPTH shifts ago.
module line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = conv_pkg::DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    shift_en,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] tail
);
    logic signed [WIDTH-1:0] mem [DEPTH];

    // Contents are never reset; the window generator's counters decide validity.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign tail = mem[DEPTH-1];
endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator (valid convolution, one frame per start).
// Optional build macro CONV_WIN_STRIDE2_EN selects stride-2 window emission.
module conv_window_gen #(
    parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic signed [DATA_WIDTH-1:0] pix_data,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic signed [DATA_WIDTH-1:0] win_data [conv_pkg::WIN_SIZE],
    output logic                         win_last,
    output logic                         busy,
    output logic                         done
);
    import conv_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int PW   = $clog2(NPIX + 1);

    win_state_t state, state_nxt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] pix_cnt;
    logic          accept;
    logic          emit;
    logic          last_win;
    logic          last_hs;

    logic signed [DATA_WIDTH-1:0] a_out;
    logic signed [DATA_WIDTH-1:0] b_out;
    logic signed [DATA_WIDTH-1:0] new_col [KERNEL];
    logic signed [DATA_WIDTH-1:0] win_p0 [WIN_SIZE];
    logic                         vld_p0;
    logic                         last_p0;

    assign pix_ready = (state == RUN) && (pix_cnt < PW'(NPIX)) && (!vld_p0 || win_ready);
    assign accept    = pix_valid && pix_ready;

`ifdef CONV_WIN_STRIDE2_EN
    localparam int LAST_R     = 2 + 2 * ((IMG_H - 3) / 2);
    localparam int LAST_C     = 2 + 2 * ((IMG_W - 3) / 2);
    localparam bit LAST_EMITS = (LAST_R == IMG_H - 1) && (LAST_C == IMG_W - 1);

    logic last_pix;

    // (r-2) and (c-2) even is the same as r and c even.
    assign emit     = (row >= RW'(2)) && (col >= CW'(2)) && !row[0] && !col[0];
    assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign last_win = (row == RW'(LAST_R)) && (col == CW'(LAST_C));
    // When the final pixel emits nothing, the frame ends on that pixel's handshake.
    assign last_hs  = LAST_EMITS ? (vld_p0 && win_ready && last_p0) : (accept && last_pix);
`else
    assign emit     = (row >= RW'(2)) && (col >= CW'(2));
    assign last_win = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign last_hs  = vld_p0 && win_ready && last_p0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_hs) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            pix_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            col     <= '0;
            row     <= '0;
            pix_cnt <= '0;
        end else if (accept) begin
            pix_cnt <= pix_cnt + PW'(1);
            if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_WIDTH)) u_line_a (
        .clk      (clk),
        .shift_en (accept),
        .din      (pix_data),
        .tail     (a_out)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_WIDTH)) u_line_b (
        .clk      (clk),
        .shift_en (accept),
        .din      (a_out),
        .tail     (b_out)
    );

    // Rightmost column: oldest row on top.
    assign new_col[0] = b_out;
    assign new_col[1] = a_out;
    assign new_col[2] = pix_data;

    // ---- stage p0: window register and its valid/last qualifiers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < WIN_SIZE; k++) win_p0[k] <= '0;
        end else if (accept) begin
            for (int i = 0; i < KERNEL; i++) begin
                win_p0[KERNEL*i]     <= win_p0[KERNEL*i + 1];
                win_p0[KERNEL*i + 1] <= win_p0[KERNEL*i + 2];
                win_p0[KERNEL*i + 2] <= new_col[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else if (accept && emit) begin
            vld_p0  <= 1'b1;
            last_p0 <= last_win;
        end else if (win_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign win_valid = vld_p0;
    assign win_last  = last_p0;
    assign win_data  = win_p0;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on a 5x5 frame: image-based window model plus literal windows.
module tb_conv_window_gen;
    localparam int W = 5;
    localparam int H = 5;
`ifdef CONV_WIN_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
`else
    localparam bit STRIDE2 = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              pix_valid;
    logic              pix_ready;
    logic signed [7:0] pix_data;
    logic              win_valid;
    logic              win_ready = 1'b1;
    logic signed [7:0] win_data [9];
    logic              win_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [72:0] exp_q [$];
    logic [72:0] rec [16];
    int          rec_n = 0;
    bit          done_seen = 1'b0;
    bit          done_exp = 1'b0;
    bit          bp_req = 1'b0;
    int          bp_cnt = 0;

    conv_window_gen #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_last  (win_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [72:0] act, input logic [72:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    endtask

    function automatic logic signed [7:0] pixval(input int kind, input int idx);
        if (kind == 0) return 8'(idx);
        return 8'(idx * 9 - 100);
    endfunction

    function automatic logic [71:0] lit(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7,
                                        input int a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [72:0] dut_win();
        logic [72:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[8*k +: 8] = win_data[k];
        v[72] = win_last;
        return v;
    endfunction

    function automatic bit emits(input int r, input int c);
        if (r < 2 || c < 2) return 1'b0;
        if (STRIDE2) return ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
        return 1'b1;
    endfunction

    // Scoreboard: every cycle the window is valid it must equal the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_n) begin
            done_exp = 1'b0;
            exp_q.delete();
        end else begin
            if (start && !busy) begin
                rec_n     = 0;
                done_seen = 1'b0;
            end
            check(done == done_exp, "done_timing", 73'(done), 73'(done_exp));
            if (done) done_seen = 1'b1;
            done_exp = 1'b0;
            if (win_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_window", dut_win(), '0);
                end else begin
                    check(dut_win() == exp_q[0], "window", dut_win(), exp_q[0]);
                    if (!win_ready) check(pix_ready == 1'b0, "stall_pix_ready", 73'(pix_ready), 73'(0));
                    if (win_ready) begin
                        if (rec_n < 16) rec[rec_n] = dut_win();
                        rec_n++;
                        done_exp = win_last;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Downstream: optionally stall the frame's first window for four cycles.
    always @(posedge clk) begin
        #1;
        if (!busy) bp_cnt = 0;
        if (bp_req && win_valid && rec_n == 0 && bp_cnt < 4) begin
            win_ready = 1'b0;
            bp_cnt++;
        end else begin
            win_ready = 1'b1;
        end
    end

    task automatic check_reset(input string tag);
        logic [72:0] w;
        w = dut_win();
        check(pix_ready == 1'b0, {tag, "_pix_ready"}, 73'(pix_ready), '0);
        check(win_valid == 1'b0, {tag, "_win_valid"}, 73'(win_valid), '0);
        check(w == '0,           {tag, "_win_data_last"}, w, '0);
        check(busy == 1'b0,      {tag, "_busy"}, 73'(busy), '0);
        check(done == 1'b0,      {tag, "_done"}, 73'(done), '0);
    endtask

    task automatic drive(input int kind, input int n, input bit mid_start);
        for (int idx = 0; idx < n; idx++) begin
            int waited;
            bit acc;
            waited    = 0;
            acc       = 1'b0;
            pix_valid = 1'b1;
            pix_data  = pixval(kind, idx);
            if (mid_start && idx == 7) start = 1'b1;
            while (!acc && waited < 100) begin
                @(negedge clk);
                acc = pix_ready;
                @(posedge clk);
                #1;
                start = 1'b0;
                waited++;
            end
            if (!acc) begin
                check(1'b0, "pix_accept_timeout", 73'(idx), 73'(n));
                break;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic run_frame(input int kind, input bit bp, input bit mid_start);
        logic signed [7:0] img [W*H];
        logic [72:0] tmp [$];
        logic [72:0] w;
        for (int i = 0; i < W*H; i++) img[i] = pixval(kind, i);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (emits(r, c)) begin
                    w = '0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            w[8*(3*i+j) +: 8] = img[(r-2+i)*W + (c-2+j)];
                    tmp.push_back(w);
                end
            end
        end
        tmp[tmp.size()-1][72] = 1'b1;
        foreach (tmp[k]) exp_q.push_back(tmp[k]);

        bp_req = bp;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check(pix_ready == 1'b1, "first_pix_ready", 73'(pix_ready), 73'(1));
        drive(kind, W*H, mid_start);
        for (int t = 0; t < 100 && !done_seen; t++) @(posedge clk);
        #1;
        check(done_seen, "done_seen", 73'(done_seen), 73'(1));
        @(posedge clk);
        #1;
        check(busy == 1'b0, "busy_after_done", 73'(busy), '0);
        check(rec_n == tmp.size(), "window_count_model", 73'(rec_n), 73'(tmp.size()));
        check(exp_q.size() == 0, "windows_outstanding", 73'(exp_q.size()), '0);
        bp_req = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("init");
        rst_n = 1'b1;

        // Aborted frame: 12 pixels, then asynchronous reset mid-frame.
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drive(0, 12, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_frame(0, 1'b0, 1'b0);
        check(rec[0] == {1'b0, lit(0, 1, 2, 5, 6, 7, 10, 11, 12)}, "first_window", rec[0],
              {1'b0, lit(0, 1, 2, 5, 6, 7, 10, 11, 12)});
`ifdef CONV_WIN_STRIDE2_EN
        check(rec_n == 4, "count_literal", 73'(rec_n), 73'(4));
        check(rec[1] == {1'b0, lit(2, 3, 4, 7, 8, 9, 12, 13, 14)}, "s2_win_tl2", rec[1],
              {1'b0, lit(2, 3, 4, 7, 8, 9, 12, 13, 14)});
        check(rec[2] == {1'b0, lit(10, 11, 12, 15, 16, 17, 20, 21, 22)}, "s2_win_tl10", rec[2],
              {1'b0, lit(10, 11, 12, 15, 16, 17, 20, 21, 22)});
        check(rec[3] == {1'b1, lit(12, 13, 14, 17, 18, 19, 22, 23, 24)}, "s2_last_tl12", rec[3],
              {1'b1, lit(12, 13, 14, 17, 18, 19, 22, 23, 24)});
`else
        check(rec_n == 9, "count_literal", 73'(rec_n), 73'(9));
        check(rec[3] == {1'b0, lit(5, 6, 7, 10, 11, 12, 15, 16, 17)}, "row_wrap_window", rec[3],
              {1'b0, lit(5, 6, 7, 10, 11, 12, 15, 16, 17)});
        check(rec[8] == {1'b1, lit(12, 13, 14, 17, 18, 19, 22, 23, 24)}, "last_window", rec[8],
              {1'b1, lit(12, 13, 14, 17, 18, 19, 22, 23, 24)});
`endif

        run_frame(0, 1'b1, 1'b0);
        check(rec[0] == {1'b0, lit(0, 1, 2, 5, 6, 7, 10, 11, 12)}, "bp_first_window", rec[0],
              {1'b0, lit(0, 1, 2, 5, 6, 7, 10, 11, 12)});
`ifndef CONV_WIN_STRIDE2_EN
        check(rec[1] == {1'b0, lit(1, 2, 3, 6, 7, 8, 11, 12, 13)}, "bp_next_window", rec[1],
              {1'b0, lit(1, 2, 3, 6, 7, 8, 11, 12, 13)});
`endif

        run_frame(0, 1'b0, 1'b1);
        run_frame(1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0t required < 200000", $time);
        $fatal(1, "timeout");
    end
endmodule
